// File: rtl/battle_pkg.sv
// Shared definitions for the battle engine turn controller: state and trainer
// encodings plus the clamped HP subtraction used by both attack states.
package battle_pkg;

   localparam logic [2:0] ST_LOAD_PM   = 3'd0;
   localparam logic [2:0] ST_P_ATTACK  = 3'd1;
   localparam logic [2:0] ST_LOAD_AM   = 3'd2;
   localparam logic [2:0] ST_AI_ATTACK = 3'd3;
   localparam logic [2:0] ST_A_FAINT   = 3'd4;
   localparam logic [2:0] ST_P_FAINT   = 3'd5;
   localparam logic [2:0] ST_VICTORY   = 3'd6;
   localparam logic [2:0] ST_LOSS      = 3'd7;

   typedef enum logic [2:0] {
      LOAD_PM   = ST_LOAD_PM,
      P_ATTACK  = ST_P_ATTACK,
      LOAD_AM   = ST_LOAD_AM,
      AI_ATTACK = ST_AI_ATTACK,
      A_FAINT   = ST_A_FAINT,
      P_FAINT   = ST_P_FAINT,
      VICTORY   = ST_VICTORY,
      LOSS      = ST_LOSS
   } state_t;

   localparam logic PLAYER = 1'b0;
   localparam logic AI     = 1'b1;

   // Operands are zero-extended to 32 bits so a damage value wider than HP
   // is compared at full width; the result never exceeds hp.
   function automatic logic [31:0] sat_sub(input logic [31:0] hp, input logic [31:0] dmg);
      return (dmg >= hp) ? 32'd0 : (hp - dmg);
   endfunction

endpackage

// File: rtl/battle_party.sv
// HP storage and active-member index for one side of the battle.
module battle_party
   import battle_pkg::*;
#(
   parameter int HP_W   = 8,
   parameter int PARTY  = 3,
   parameter int MAX_HP = 100,
   parameter int IDX_W  = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              dmg_we_i,
   input  logic [HP_W-1:0]   dmg_res_i,
   input  logic              next_i,
   input  logic              refill_i,
   output logic [IDX_W-1:0]  idx_o,
   output logic [HP_W-1:0]   hp_active_o,
   output logic              fainted_all_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PARTY - 1);

   logic [HP_W-1:0]  hp_q [PARTY];
   logic [IDX_W-1:0] idx_q;
   logic             all_zero;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < PARTY; i++) hp_q[i] <= HP_W'(MAX_HP);
         idx_q <= '0;
      end else if (refill_i) begin
         for (int i = 0; i < PARTY; i++) hp_q[i] <= HP_W'(MAX_HP);
         idx_q <= '0;
      end else begin
         if (dmg_we_i) hp_q[idx_q] <= dmg_res_i;
         // The last member never advances, which also pins a single-member party at 0.
         if (next_i && (idx_q != LAST_IDX)) idx_q <= idx_q + IDX_W'(1);
      end
   end

   always_comb begin
      all_zero = 1'b1;
      for (int i = 0; i < PARTY; i++) begin
         if (hp_q[i] != '0) all_zero = 1'b0;
      end
   end

   assign idx_o         = idx_q;
   assign hp_active_o   = hp_q[idx_q];
   assign fainted_all_o = all_zero;

endmodule

// File: rtl/battle_turn_ctrl.sv
// Turn controller: alternates player/AI moves, applies clamped damage to the
// opposing active Pokemon, switches on faint and declares the battle result.
module battle_turn_ctrl
   import battle_pkg::*;
#(
   parameter int HP_W   = 8,
   parameter int DMG_W  = 8,
   parameter int PARTY  = 3,
   parameter int MAX_HP = 100,
   localparam int IDX_W = (PARTY > 1) ? $clog2(PARTY) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             go,
   input  logic             new_battle,
   input  logic [DMG_W-1:0] move_dmg,
   output logic [2:0]       state,
   output logic             active_trainer,
   output logic             apply_damage,
   output logic [IDX_W-1:0] p_idx,
   output logic [IDX_W-1:0] a_idx,
   output logic [HP_W-1:0]  p_hp,
   output logic [HP_W-1:0]  a_hp,
   output logic [7:0]       turn_count,
   output logic             victory,
   output logic             loss
);

   state_t           state_q, state_d;
   logic [DMG_W-1:0] dmg_q, dmg_d;
   logic [7:0]       turn_q, turn_d;
   logic             apply_q, trainer_q, victory_q, loss_q;

   logic [HP_W-1:0]  target_hp, res;
   logic             p_we, a_we, p_next, a_next, refill;
   logic             p_all, a_all;

   assign target_hp = (state_q == AI_ATTACK) ? p_hp : a_hp;
   assign res       = HP_W'(sat_sub(32'(target_hp), 32'(dmg_q)));

   battle_party #(.HP_W(HP_W), .PARTY(PARTY), .MAX_HP(MAX_HP), .IDX_W(IDX_W)) u_player (
      .clk_i         (clk),
      .rst_ni        (reset_n),
      .dmg_we_i      (p_we),
      .dmg_res_i     (res),
      .next_i        (p_next),
      .refill_i      (refill),
      .idx_o         (p_idx),
      .hp_active_o   (p_hp),
      .fainted_all_o (p_all)
   );

   battle_party #(.HP_W(HP_W), .PARTY(PARTY), .MAX_HP(MAX_HP), .IDX_W(IDX_W)) u_ai (
      .clk_i         (clk),
      .rst_ni        (reset_n),
      .dmg_we_i      (a_we),
      .dmg_res_i     (res),
      .next_i        (a_next),
      .refill_i      (refill),
      .idx_o         (a_idx),
      .hp_active_o   (a_hp),
      .fainted_all_o (a_all)
   );

   always_comb begin
      state_d = state_q;
      dmg_d   = dmg_q;
      turn_d  = turn_q;
      p_we    = 1'b0;
      a_we    = 1'b0;
      p_next  = 1'b0;
      a_next  = 1'b0;
      refill  = 1'b0;
      if (new_battle) begin
         state_d = LOAD_PM;
         turn_d  = '0;
         refill  = 1'b1;
      end else begin
         case (state_q)
            LOAD_PM: if (go) begin
               dmg_d   = move_dmg;
               state_d = P_ATTACK;
            end
            P_ATTACK: begin
               a_we    = 1'b1;
               state_d = (res == '0) ? A_FAINT : LOAD_AM;
            end
            LOAD_AM: if (go) begin
               dmg_d   = move_dmg;
               state_d = AI_ATTACK;
            end
            AI_ATTACK: begin
               p_we    = 1'b1;
               turn_d  = (turn_q == 8'hFF) ? turn_q : turn_q + 8'd1;
               state_d = (res == '0) ? P_FAINT : LOAD_PM;
            end
            // Switches only happen on a faint, so every earlier slot is already at 0.
            A_FAINT: begin
               if (a_all) state_d = VICTORY;
               else begin
                  a_next  = 1'b1;
                  state_d = LOAD_AM;
               end
            end
            P_FAINT: begin
               if (p_all) state_d = LOSS;
               else begin
                  p_next  = 1'b1;
                  state_d = LOAD_PM;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= LOAD_PM;
         dmg_q     <= '0;
         turn_q    <= '0;
         apply_q   <= 1'b0;
         trainer_q <= PLAYER;
         victory_q <= 1'b0;
         loss_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dmg_q     <= dmg_d;
         turn_q    <= turn_d;
         apply_q   <= (state_d == P_ATTACK) || (state_d == AI_ATTACK);
         trainer_q <= ((state_d == LOAD_AM) || (state_d == AI_ATTACK)) ? AI : PLAYER;
         victory_q <= (state_d == VICTORY);
         loss_q    <= (state_d == LOSS);
      end
   end

   assign state          = state_q;
   assign active_trainer = trainer_q;
   assign apply_damage   = apply_q;
   assign turn_count     = turn_q;
   assign victory        = victory_q;
   assign loss           = loss_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Bench for battle_turn_ctrl: directed scenarios plus random play, compared
// every cycle against a rule-level model of the battle.
module tb_battle_turn_ctrl;
   import battle_pkg::*;

   localparam int PARTY  = 3;
   localparam int MAX_HP = 100;

   logic       clk = 1'b0;
   logic       reset_n, go, new_battle;
   logic [7:0] move_dmg;
   logic [2:0] state;
   logic       active_trainer, apply_damage, victory, loss;
   logic [1:0] p_idx, a_idx;
   logic [7:0] p_hp, a_hp, turn_count;

   always #5 clk = ~clk;

   battle_turn_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .go             (go),
      .new_battle     (new_battle),
      .move_dmg       (move_dmg),
      .state          (state),
      .active_trainer (active_trainer),
      .apply_damage   (apply_damage),
      .p_idx          (p_idx),
      .a_idx          (a_idx),
      .p_hp           (p_hp),
      .a_hp           (a_hp),
      .turn_count     (turn_count),
      .victory        (victory),
      .loss           (loss)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Rule-level model of the battle
   int m_st, m_pi, m_ai, m_turn, m_dmg;
   int m_php [PARTY];
   int m_ahp [PARTY];

   function automatic void m_restart();
      foreach (m_php[i]) m_php[i] = MAX_HP;
      foreach (m_ahp[i]) m_ahp[i] = MAX_HP;
      m_pi   = 0;
      m_ai   = 0;
      m_turn = 0;
      m_st   = int'(LOAD_PM);
   endfunction

   function automatic void m_step();
      if (new_battle) begin
         m_restart();
         return;
      end
      case (m_st)
         int'(LOAD_PM): if (go) begin m_dmg = move_dmg; m_st = int'(P_ATTACK); end
         int'(LOAD_AM): if (go) begin m_dmg = move_dmg; m_st = int'(AI_ATTACK); end
         int'(P_ATTACK): begin
            m_ahp[m_ai] = (m_dmg >= m_ahp[m_ai]) ? 0 : m_ahp[m_ai] - m_dmg;
            m_st = (m_ahp[m_ai] == 0) ? int'(A_FAINT) : int'(LOAD_AM);
         end
         int'(AI_ATTACK): begin
            m_php[m_pi] = (m_dmg >= m_php[m_pi]) ? 0 : m_php[m_pi] - m_dmg;
            m_turn = (m_turn < 255) ? m_turn + 1 : 255;
            m_st = (m_php[m_pi] == 0) ? int'(P_FAINT) : int'(LOAD_PM);
         end
         int'(A_FAINT): begin
            if (m_ai == PARTY - 1) m_st = int'(VICTORY);
            else begin m_ai++; m_st = int'(LOAD_AM); end
         end
         int'(P_FAINT): begin
            if (m_pi == PARTY - 1) m_st = int'(LOSS);
            else begin m_pi++; m_st = int'(LOAD_PM); end
         end
         default: ;
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_restart();
         m_dmg = 0;
      end else m_step();
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("state", state, m_st);
         chk("active_trainer", active_trainer,
             int'(m_st == int'(LOAD_AM) || m_st == int'(AI_ATTACK)));
         chk("apply_damage", apply_damage,
             int'(m_st == int'(P_ATTACK) || m_st == int'(AI_ATTACK)));
         chk("p_idx", p_idx, m_pi);
         chk("a_idx", a_idx, m_ai);
         chk("p_hp", p_hp, m_php[m_pi]);
         chk("a_hp", a_hp, m_ahp[m_ai]);
         chk("turn_count", turn_count, m_turn);
         chk("victory", victory, int'(m_st == int'(VICTORY)));
         chk("loss", loss, int'(m_st == int'(LOSS)));
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget);
      for (int i = 0; i < budget && state !== st; i++) cyc();
      chk("wait_state", state, int'(st));
   endtask

   task automatic move(input logic [2:0] st, input int dmg);
      wait_state(st, 20);
      go       = 1'b1;
      move_dmg = 8'(dmg);
      cyc();
      go       = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_state"}, state, int'(LOAD_PM));
      chk({tag, "_p_hp"}, p_hp, 100);
      chk({tag, "_a_hp"}, a_hp, 100);
      chk({tag, "_p_idx"}, p_idx, 0);
      chk({tag, "_a_idx"}, a_idx, 0);
      chk({tag, "_turn"}, turn_count, 0);
      chk({tag, "_flags"}, {victory, loss, apply_damage, active_trainer}, 0);
   endtask

   initial begin
      reset_n    = 1'b0;
      go         = 1'b0;
      new_battle = 1'b0;
      move_dmg   = '0;
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
      cmp_en = 1'b1;
      check_reset_values("por");

      // First hit, then an asynchronous reset between clock edges
      move(LOAD_PM, 30);
      chk("hit30_state", state, int'(P_ATTACK));
      chk("hit30_apply", apply_damage, 1);
      cyc();
      chk("hit30_a_hp", a_hp, 70);
      chk("hit30_next", state, int'(LOAD_AM));
      chk("hit30_trainer", active_trainer, 1);
      #2 reset_n = 1'b0;
      #1 check_reset_values("async");
      cyc();
      reset_n = 1'b1;

      // Clamp to zero and switch to the next AI Pokemon
      move(LOAD_PM, 30);
      cyc();
      chk("a_hp_70", a_hp, 70);
      move(LOAD_AM, 0);
      cyc();
      chk("zero_dmg_p_hp", p_hp, 100);
      chk("turn_1", turn_count, 1);
      move(LOAD_PM, 255);
      cyc();
      chk("clamp_state", state, int'(A_FAINT));
      chk("clamp_a_hp", a_hp, 0);
      cyc();
      chk("switch_a_idx", a_idx, 1);
      chk("switch_a_hp", a_hp, 100);
      chk("switch_state", state, int'(LOAD_AM));

      // Knock out the rest of the AI party
      repeat (2) begin
         move(LOAD_AM, 0);
         move(LOAD_PM, 255);
      end
      wait_state(VICTORY, 10);
      chk("victory_flag", victory, 1);
      go = 1'b1; move_dmg = 8'd50;
      cyc();
      go = 1'b0;
      cyc();
      chk("victory_ignores_go", state, int'(VICTORY));
      new_battle = 1'b1;
      cyc();
      new_battle = 1'b0;
      check_reset_values("restart");

      // Player party wiped by exact-HP hits
      repeat (3) begin
         move(LOAD_PM, 0);
         move(LOAD_AM, 100);
      end
      wait_state(LOSS, 10);
      chk("loss_flag", loss, 1);
      chk("loss_p_idx", p_idx, 2);
      chk("loss_p_hp", p_hp, 0);
      new_battle = 1'b1;
      cyc();
      new_battle = 1'b0;

      // Random play
      repeat (4000) begin
         go         = ($urandom_range(0, 2) == 0);
         new_battle = ($urandom_range(0, 99) == 0);
         case ($urandom_range(0, 4))
            0: move_dmg = 8'd0;
            1: move_dmg = 8'd100;
            2: move_dmg = 8'd255;
            3: move_dmg = 8'($urandom_range(1, 60));
            default: move_dmg = 8'($urandom_range(0, 255));
         endcase
         cyc();
      end
      go = 1'b0;
      new_battle = 1'b1;
      cyc();
      new_battle = 1'b0;

      // Long harmless battle saturates the round counter
      repeat (300) begin
         move(LOAD_PM, 0);
         move(LOAD_AM, 0);
      end
      chk("sat_state", state, int'(AI_ATTACK));
      chk("sat_turn", turn_count, 255);
      #2 reset_n = 1'b0;
      #1 check_reset_values("sat_reset");
      cyc();
      reset_n = 1'b1;
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
